// File: rtl/fc_layer_engine.sv
// fc_layer_engine
//
// Fully-connected layer engine for the classifier back end. For every one of
// CHANNELS input vectors (IN_LEN elements each) it computes OUT_LEN dot
// products against a shared weight matrix. It then adds a per-neuron bias,
// requantises by an arithmetic right shift, optionally applies ReLU, and
// writes one saturated DATA_W result per neuron.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         one-cycle run request, ignored unless idle
//   relu_en       ReLU select, latched on an accepted start
//   busy, done    run in progress / one-cycle completion pulse
//   d_rd_*        feature RAM read port   (addr = ch*IN_LEN + k, 1-cycle latency)
//   w_rd_*        weight ROM read port    (addr = o*IN_LEN + k,  1-cycle latency)
//   b_rd_*        bias ROM read port      (addr = o,             1-cycle latency)
//   o_wr_*        result RAM write port   (addr = ch*OUT_LEN + o)
//   acc_ovf       sticky accumulator-saturation flag, cleared on accepted start
module fc_layer_engine #(
    parameter int IN_LEN     = 240,
    parameter int OUT_LEN    = 64,
    parameter int CHANNELS   = 42,
    parameter int DATA_W     = 8,
    parameter int WEIGHT_W   = 8,
    parameter int BIAS_W     = 8,
    parameter int ACC_W      = 32,
    parameter int BIAS_SHIFT = 0,
    parameter int OUT_SHIFT  = 8,
    parameter int DADDR_W    = 15,
    parameter int WADDR_W    = 14,
    parameter int OADDR_W    = 12,
    localparam int O_W       = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       relu_en,
    output logic                       busy,
    output logic                       done,
    output logic                       d_rd_en,
    output logic [DADDR_W-1:0]         d_rd_addr,
    input  logic signed [DATA_W-1:0]   d_rd_data,
    output logic                       w_rd_en,
    output logic [WADDR_W-1:0]         w_rd_addr,
    input  logic signed [WEIGHT_W-1:0] w_rd_data,
    output logic                       b_rd_en,
    output logic [O_W-1:0]             b_rd_addr,
    input  logic signed [BIAS_W-1:0]   b_rd_data,
    output logic                       o_wr_en,
    output logic [OADDR_W-1:0]         o_wr_addr,
    output logic signed [DATA_W-1:0]   o_wr_data,
    output logic                       acc_ovf
);

    localparam int K_W    = $clog2(IN_LEN);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PROD_W = DATA_W + WEIGHT_W;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] RES_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RES_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [CH_W-1:0]           ch_cnt;
    logic [O_W-1:0]            o_cnt;
    logic [K_W-1:0]            k_cnt;
    logic signed [ACC_W-1:0]   acc;
    logic                      relu_lat;

    logic                      k_last;
    logic                      o_last;
    logic                      ch_last;

    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   addend;
    logic signed [ACC_W:0]     sum_wide;
    logic signed [ACC_W-1:0]   sum_sat;
    logic                      sum_ovf;
    logic                      acc_step;
    logic                      acc_first;

    logic signed [ACC_W-1:0]   shifted;
    logic signed [ACC_W-1:0]   clipped;

    assign k_last  = (k_cnt  == K_W'(IN_LEN - 1));
    assign o_last  = (o_cnt  == O_W'(OUT_LEN - 1));
    assign ch_last = (ch_cnt == CH_W'(CHANNELS - 1));

    // Read data arrives one cycle after the issuing MAC cycle, so products are
    // accumulated from MAC k=1 through DRAIN. The k=1 product is the first of a
    // neuron and is combined with the bias instead of the stale accumulator.
    assign acc_step  = ((state == S_MAC) && (k_cnt != '0)) || (state == S_DRAIN);
    assign acc_first = (state == S_MAC) && (k_cnt == K_W'(1));

    // Saturating accumulate: one extra sign bit exposes overflow of the sum.
    always_comb begin
        prod     = PROD_W'(d_rd_data) * PROD_W'(w_rd_data);
        prod_ext = ACC_W'(prod);
        bias_ext = ACC_W'(b_rd_data) <<< BIAS_SHIFT;
        addend   = acc_first ? bias_ext : acc;
        sum_wide = (ACC_W+1)'(addend) + (ACC_W+1)'(prod_ext);
        sum_ovf  = (sum_wide[ACC_W] != sum_wide[ACC_W-1]);
        sum_sat  = sum_wide[ACC_W-1:0];
        if (sum_ovf) begin
            sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Requantisation of the finished accumulator: shift, optional ReLU, clip.
    always_comb begin
        shifted = acc >>> OUT_SHIFT;
        if (relu_lat && shifted[ACC_W-1]) begin
            shifted = '0;
        end
        clipped = shifted;
        if (shifted > RES_MAX) begin
            clipped = RES_MAX;
        end else if (shifted < RES_MIN) begin
            clipped = RES_MIN;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_MAC;
            S_MAC:   if (k_last) state_next = S_DRAIN;
            S_DRAIN: state_next = S_WRITE;
            S_WRITE: state_next = (o_last && ch_last) ? S_DONE : S_MAC;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from state and also forced low while rst is high, so
    // no strobe can escape in the reset cycle itself.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        d_rd_en   = 1'b0;
        d_rd_addr = '0;
        w_rd_en   = 1'b0;
        w_rd_addr = '0;
        b_rd_en   = 1'b0;
        b_rd_addr = '0;
        o_wr_en   = 1'b0;
        o_wr_addr = '0;
        o_wr_data = '0;
        if (!rst) begin
            case (state)
                S_MAC: begin
                    busy      = 1'b1;
                    d_rd_en   = 1'b1;
                    d_rd_addr = DADDR_W'(ch_cnt) * DADDR_W'(IN_LEN) + DADDR_W'(k_cnt);
                    w_rd_en   = 1'b1;
                    w_rd_addr = WADDR_W'(o_cnt) * WADDR_W'(IN_LEN) + WADDR_W'(k_cnt);
                    if (k_cnt == '0) begin
                        b_rd_en   = 1'b1;
                        b_rd_addr = o_cnt;
                    end
                end
                S_DRAIN: busy = 1'b1;
                S_WRITE: begin
                    busy      = 1'b1;
                    o_wr_en   = 1'b1;
                    o_wr_addr = OADDR_W'(ch_cnt) * OADDR_W'(OUT_LEN) + OADDR_W'(o_cnt);
                    o_wr_data = clipped[DATA_W-1:0];
                end
                S_DONE:  done = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ch_cnt   <= '0;
            o_cnt    <= '0;
            k_cnt    <= '0;
            acc      <= '0;
            relu_lat <= 1'b0;
            acc_ovf  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        relu_lat <= relu_en;
                        acc_ovf  <= 1'b0;
                    end
                end
                S_MAC: begin
                    k_cnt <= k_last ? '0 : k_cnt + K_W'(1);
                end
                S_WRITE: begin
                    if (o_last) begin
                        o_cnt  <= '0;
                        ch_cnt <= ch_last ? '0 : ch_cnt + CH_W'(1);
                    end else begin
                        o_cnt <= o_cnt + O_W'(1);
                    end
                end
                default: ;
            endcase
            if (acc_step) begin
                acc <= sum_sat;
                if (sum_ovf) begin
                    acc_ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_engine.sv
// tb_fc_layer_engine
//
// Self-checking bench for fc_layer_engine on a small configuration. Holds the
// feature/weight/bias memories as 1-cycle-latency models, computes expected
// results with a plain arithmetic reference, and checks write data, all
// read/write address sequences, run timing, done/busy behaviour, acc_ovf,
// ignored starts and a mid-run reset.
module tb_fc_layer_engine;

    localparam int IN_LEN     = 4;
    localparam int OUT_LEN    = 3;
    localparam int CHANNELS   = 2;
    localparam int DATA_W     = 8;
    localparam int WEIGHT_W   = 8;
    localparam int BIAS_W     = 8;
    localparam int ACC_W      = 16;
    localparam int BIAS_SHIFT = 2;
    localparam int OUT_SHIFT  = 2;
    localparam int DADDR_W    = 4;
    localparam int WADDR_W    = 4;
    localparam int OADDR_W    = 3;
    localparam int O_W        = 2;
    localparam int NEURONS    = CHANNELS * OUT_LEN;
    localparam int RUN_CYCLES = NEURONS * (IN_LEN + 2) + 1;
    localparam longint AMAX   = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint AMIN   = -(64'sd1 <<< (ACC_W - 1));

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic relu_en;
    logic busy;
    logic done;
    logic d_rd_en;
    logic [DADDR_W-1:0] d_rd_addr;
    logic signed [DATA_W-1:0] d_rd_data;
    logic w_rd_en;
    logic [WADDR_W-1:0] w_rd_addr;
    logic signed [WEIGHT_W-1:0] w_rd_data;
    logic b_rd_en;
    logic [O_W-1:0] b_rd_addr;
    logic signed [BIAS_W-1:0] b_rd_data;
    logic o_wr_en;
    logic [OADDR_W-1:0] o_wr_addr;
    logic signed [DATA_W-1:0] o_wr_data;
    logic acc_ovf;

    logic signed [DATA_W-1:0]   feat_mem [0:(1<<DADDR_W)-1];
    logic signed [WEIGHT_W-1:0] w_mem    [0:(1<<WADDR_W)-1];
    logic signed [BIAS_W-1:0]   b_mem    [0:(1<<O_W)-1];

    int exp_wr_addr[$];
    int exp_wr_data[$];
    int exp_d_addr[$];
    int exp_w_addr[$];
    int exp_b_addr[$];

    int checks = 0;
    int fails  = 0;
    int cycle  = 0;
    int wr_count = 0;
    int first_wr_cycle = 0;
    int last_wr_cycle  = 0;

    fc_layer_engine #(
        .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .CHANNELS(CHANNELS),
        .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .BIAS_W(BIAS_W),
        .ACC_W(ACC_W), .BIAS_SHIFT(BIAS_SHIFT), .OUT_SHIFT(OUT_SHIFT),
        .DADDR_W(DADDR_W), .WADDR_W(WADDR_W), .OADDR_W(OADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
        .busy(busy), .done(done),
        .d_rd_en(d_rd_en), .d_rd_addr(d_rd_addr), .d_rd_data(d_rd_data),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .acc_ovf(acc_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Synchronous memories with one cycle of read latency.
    always @(posedge clk) begin
        if (d_rd_en) d_rd_data <= feat_mem[d_rd_addr];
        if (w_rd_en) w_rd_data <= w_mem[w_rd_addr];
        if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag,
                     $signed(observed), $signed(expected));
        end
    endtask

    // Every strobe seen on the memory ports is matched against the next
    // expected access in order.
    always @(negedge clk) begin
        if (o_wr_en === 1'b1) begin
            if (exp_wr_addr.size() == 0) begin
                checkOutput("wr_unexpected", exp_wr_addr.size(), 1);
            end else begin
                checkOutput("wr_addr", o_wr_addr, exp_wr_addr.pop_front());
                checkOutput("wr_data", o_wr_data, exp_wr_data.pop_front());
            end
            if (wr_count == 0) first_wr_cycle = cycle;
            last_wr_cycle = cycle;
            wr_count++;
        end
        if (d_rd_en === 1'b1) begin
            if (exp_d_addr.size() == 0) begin
                checkOutput("rd_unexpected", exp_d_addr.size(), 1);
            end else begin
                checkOutput("d_rd_addr", d_rd_addr, exp_d_addr.pop_front());
                checkOutput("w_rd_addr", w_rd_addr, exp_w_addr.pop_front());
            end
            checkOutput("w_rd_en", w_rd_en, 1);
        end
        if (b_rd_en === 1'b1) begin
            if (exp_b_addr.size() == 0) begin
                checkOutput("b_unexpected", exp_b_addr.size(), 1);
            end else begin
                checkOutput("b_rd_addr", b_rd_addr, exp_b_addr.pop_front());
            end
        end
    end

    // Reference model: dot product with a saturating running sum, shift,
    // optional ReLU, clip to the output range.
    task automatic buildExpected(input bit relu, output bit ovf);
        longint acc;
        longint s;
        longint r;
        ovf = 1'b0;
        exp_wr_addr.delete(); exp_wr_data.delete();
        exp_d_addr.delete(); exp_w_addr.delete(); exp_b_addr.delete();
        for (int ch = 0; ch < CHANNELS; ch++) begin
            for (int o = 0; o < OUT_LEN; o++) begin
                acc = 0;
                exp_b_addr.push_back(o);
                for (int k = 0; k < IN_LEN; k++) begin
                    exp_d_addr.push_back(ch * IN_LEN + k);
                    exp_w_addr.push_back(o * IN_LEN + k);
                    s = longint'(feat_mem[ch*IN_LEN+k]) * longint'(w_mem[o*IN_LEN+k]);
                    if (k == 0) s = s + longint'(b_mem[o]) * (64'sd1 <<< BIAS_SHIFT);
                    else        s = s + acc;
                    if (s > AMAX) begin s = AMAX; ovf = 1'b1; end
                    if (s < AMIN) begin s = AMIN; ovf = 1'b1; end
                    acc = s;
                end
                r = acc >>> OUT_SHIFT;
                if (relu && r < 0) r = 0;
                if (r > 127)  r = 127;
                if (r < -128) r = -128;
                exp_wr_addr.push_back(ch * OUT_LEN + o);
                exp_wr_data.push_back(int'(r));
            end
        end
    endtask

    task automatic fillConst(input int f, input int w, input int b);
        for (int i = 0; i < (1<<DADDR_W); i++) feat_mem[i] = DATA_W'(f);
        for (int i = 0; i < (1<<WADDR_W); i++) w_mem[i] = WEIGHT_W'(w);
        for (int i = 0; i < (1<<O_W); i++)     b_mem[i] = BIAS_W'(b);
    endtask

    task automatic fillRandom();
        for (int i = 0; i < (1<<DADDR_W); i++) feat_mem[i] = DATA_W'($urandom_range(0, 255));
        for (int i = 0; i < (1<<WADDR_W); i++) w_mem[i] = WEIGHT_W'($urandom_range(0, 255));
        for (int i = 0; i < (1<<O_W); i++)     b_mem[i] = BIAS_W'($urandom_range(0, 255));
    endtask

    // One full run. glitch_at > 0 pulses start (with inverted relu_en) that many
    // cycles after acceptance; a start is also pulsed in the done cycle.
    task automatic applyStimulus(input string name, input bit relu, input int glitch_at);
        bit exp_ovf;
        bit got_done;
        int accept;
        int done_cycle;
        buildExpected(relu, exp_ovf);
        wr_count = 0;
        got_done = 1'b0;
        done_cycle = 0;
        @(negedge clk);
        start = 1'b1;
        relu_en = relu;
        accept = cycle;
        @(negedge clk);
        start = 1'b0;
        relu_en = ~relu;
        checkOutput({name, "/busy_after_start"}, busy, 1);
        checkOutput({name, "/ovf_cleared"}, acc_ovf, 0);
        while (!got_done && (cycle - accept) <= RUN_CYCLES + 10) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
                done_cycle = cycle;
            end else begin
                start = (glitch_at > 0) && ((cycle - accept) == glitch_at);
                @(negedge clk);
            end
        end
        checkOutput({name, "/done_seen"}, got_done, 1);
        if (got_done) begin
            checkOutput({name, "/run_cycles"}, done_cycle - accept, RUN_CYCLES);
            checkOutput({name, "/first_write"}, first_wr_cycle - accept, IN_LEN + 2);
            checkOutput({name, "/done_after_write"}, done_cycle - last_wr_cycle, 1);
            checkOutput({name, "/write_count"}, wr_count, NEURONS);
            checkOutput({name, "/acc_ovf"}, acc_ovf, exp_ovf);
            checkOutput({name, "/busy_in_done"}, busy, 0);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checkOutput({name, "/done_one_cycle"}, done, 0);
            checkOutput({name, "/start_in_done_ignored"}, busy, 0);
            @(negedge clk);
            checkOutput({name, "/still_idle"}, busy, 0);
        end
        checkOutput({name, "/queues_drained"},
                    exp_wr_addr.size() + exp_d_addr.size() + exp_b_addr.size(), 0);
    endtask

    // Reset during neuron 1 MAC after neuron 0 has already saturated.
    task automatic resetMidRun();
        bit unused_ovf;
        buildExpected(1'b0, unused_ovf);
        wr_count = 0;
        @(negedge clk);
        start = 1'b1;
        relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (IN_LEN + 3) @(negedge clk);
        checkOutput("abort/ovf_before", acc_ovf, 1);
        checkOutput("abort/busy_before", busy, 1);
        checkOutput("abort/one_write", wr_count, 1);
        checkOutput("abort/rd_en_before", d_rd_en, 1);
        rst = 1'b1;
        #1;
        checkOutput("abort/busy_in_reset", busy, 0);
        checkOutput("abort/rd_en_in_reset", d_rd_en, 0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort/busy_after", busy, 0);
        checkOutput("abort/wr_en_after", o_wr_en, 0);
        checkOutput("abort/ovf_after", acc_ovf, 0);
        checkOutput("abort/rd_en_after", d_rd_en, 0);
        @(negedge clk);
        checkOutput("abort/idle", busy, 0);
        checkOutput("abort/write_count", wr_count, 1);
        exp_wr_addr.delete(); exp_wr_data.delete();
        exp_d_addr.delete(); exp_w_addr.delete(); exp_b_addr.delete();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        relu_en = 1'b0;
        fillConst(0, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("reset/busy", busy, 0);
        checkOutput("reset/done", done, 0);
        checkOutput("reset/d_rd_en", d_rd_en, 0);
        checkOutput("reset/b_rd_en", b_rd_en, 0);
        checkOutput("reset/o_wr_en", o_wr_en, 0);
        checkOutput("reset/acc_ovf", acc_ovf, 0);
        checkOutput("reset/d_rd_addr", d_rd_addr, 0);
        checkOutput("reset/o_wr_data", o_wr_data, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset/o_wr_en", o_wr_en, 0);

        fillConst(1, 2, 3);
        applyStimulus("ones", 1'b0, 0);
        fillConst(1, -5, 0);
        applyStimulus("relu_on", 1'b1, 0);
        applyStimulus("relu_off", 1'b0, 9);
        fillConst(127, 127, 0);
        applyStimulus("sat_pos", 1'b0, 0);
        fillConst(-100, 100, 0);
        applyStimulus("sat_neg", 1'b0, 0);
        fillConst(127, 127, 127);
        resetMidRun();
        applyStimulus("rerun", 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            fillRandom();
            applyStimulus($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                          int'($urandom_range(2, RUN_CYCLES - 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fc_layer_engine.md
Name: fc_layer_engine

Overview:
Parametrised fully-connected layer engine for the CNN classifier back end. For each of CHANNELS input vectors of IN_LEN elements it computes OUT_LEN dot products against a shared weight matrix, adds a per-neuron bias, requantises, optionally applies ReLU and writes one DATA_W result per neuron. It sits between the feature RAM written by the previous stage and the result RAM read by the next FC stage. All memories are external synchronous RAMs/ROMs with a 1-cycle read latency.

Parameters:
IN_LEN, 240, elements per input vector (>=2)
OUT_LEN, 64, output neurons per channel
CHANNELS, 42, number of input vectors processed per start
DATA_W, 8, signed input/output data width
WEIGHT_W, 8, signed weight width
BIAS_W, 8, signed bias width
ACC_W, 32, signed accumulator width
BIAS_SHIFT, 0, left shift applied to bias before adding
OUT_SHIFT, 8, arithmetic right shift applied before output saturation
DADDR_W, 15, feature read address width (>= clog2(CHANNELS*IN_LEN))
WADDR_W, 14, weight read address width (>= clog2(OUT_LEN*IN_LEN))
OADDR_W, 12, result write address width (>= clog2(CHANNELS*OUT_LEN))

Ports:
clk  input  1  rising-edge clock, only clock in the block
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin a full run; ignored while busy
relu_en  input  1  1 = apply ReLU to results; sampled on accepted start
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse after the final result write
d_rd_en  output  1  feature RAM read enable
d_rd_addr  output  DADDR_W  feature address = ch*IN_LEN + k
d_rd_data  input  DATA_W  feature data, valid 1 cycle after d_rd_en
w_rd_en  output  1  weight ROM read enable
w_rd_addr  output  WADDR_W  weight address = o*IN_LEN + k
w_rd_data  input  WEIGHT_W  weight, valid 1 cycle after w_rd_en
b_rd_en  output  1  bias ROM read enable
b_rd_addr  output  clog2(OUT_LEN)  bias address = o
b_rd_data  input  BIAS_W  bias, valid 1 cycle after b_rd_en
o_wr_en  output  1  result write strobe
o_wr_addr  output  OADDR_W  result address = ch*OUT_LEN + o
o_wr_data  output  DATA_W  requantised result
acc_ovf  output  1  sticky: any accumulator saturation since last accepted start

Behaviour:
- Reset (any cycle, including mid-run): state IDLE; counters ch,o,k = 0; accumulator 0; busy, done, all *_en, acc_ovf = 0; all addresses and o_wr_data = 0. No write issued in the reset cycle or the cycle after.
- FSM: IDLE -> MAC on start; MAC -> DRAIN after k = IN_LEN-1 issued; DRAIN -> WRITE; WRITE -> MAC (next neuron) or DONE after last neuron; DONE -> IDLE (done=1 this cycle).
- Accepted start clears acc_ovf, latches relu_en, sets busy next cycle.
- MAC, cycle k (0..IN_LEN-1): d_rd_en = w_rd_en = 1 with addresses above. At k=0 also b_rd_en = 1, b_rd_addr = o.
- Accumulate: product of element k added in the following cycle; at k=1 (first product) accumulator loads product + (sext(bias) << BIAS_SHIFT), discarding previous neuron's value. Last product added in DRAIN.
- Products: full signed DATA_W x WEIGHT_W, sign-extended to ACC_W. Additions saturate to ACC_W signed range; any saturation sets acc_ovf.
- WRITE: r = acc >>> OUT_SHIFT (arithmetic); if latched relu and r<0 then r=0; saturate r to signed DATA_W range; o_wr_en=1 for exactly this cycle.
- Ordering: o increments after each WRITE; at o=OUT_LEN-1 it wraps to 0 and ch increments; after ch=CHANNELS-1, o=OUT_LEN-1 go to DONE.
- Latency: IN_LEN+2 cycles per neuron; first write in cycle IN_LEN+2 after start acceptance; done one cycle after the final write; total run = CHANNELS*OUT_LEN*(IN_LEN+2)+1 cycles from acceptance to done.
- start while busy or in DONE: ignored, no effect on counters. start in the cycle done is high: ignored; next start is accepted from IDLE.
- Read enables are low outside MAC; o_wr_en is low outside WRITE.

Test Plan:
- IN_LEN=4, OUT_LEN=2, CHANNELS=2, OUT_SHIFT=0. Features all 1, weights all 2, bias 3 -> 4 writes of 11 at addresses 0..3, done 1 cycle after 4th write, 25 cycles total.
- Same config, weights -5, bias 0, relu_en=1 -> all outputs 0. relu_en=0 -> all outputs -20.
- Features 127, weights 127, IN_LEN=4, OUT_SHIFT=0 -> acc 64516, output saturates to 127. With ACC_W=16 -> acc_ovf=1.
- OUT_SHIFT=8, features 100, weights 100, IN_LEN=4 -> acc 40000, >>>8 = 156 -> output 127. Features -100 -> output -157 -> saturated to -128.
- Assert rst mid-MAC of neuron 1 -> next cycle busy=0, no o_wr_en, acc_ovf=0. New start reruns from address 0 with correct results.
- Pulse start while busy -> ignored. Read and write address sequences match ch*IN_LEN+k, o*IN_LEN+k and ch*OUT_LEN+o exactly.
